// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package mem_arbiter_pkg;

  // FSM encoding; the numeric values are visible on debug probes.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  // Requester port indices as seen by the round-robin pointer.
  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_D  = 1'b1;

  // Default minimum hold of a memory command before mem_ready is honoured.
  localparam int MIN_WAIT_DEFAULT = 2;

  // Wait counter width; covers MIN_WAIT values 0..15.
  localparam int CNT_W = 4;

endpackage

// File: rtl/mem_arbiter_rr.sv
// Two-way round-robin grant selection.
// Latency: combinational.
// Backpressure: none; the caller decides when the grant is consumed.
module rr_arbiter2
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant
);

  // On contention the port not granted last wins; a lone request wins outright.
  always_comb begin
    grant = PORT_IF;
    if (req == 2'b11) begin
      grant = ~last;
    end else if (req[PORT_D]) begin
      grant = PORT_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port and a data port onto one shared data memory.
// Latency: req-to-ack MIN_WAIT+2 cycles with mem_ready high; one access per MIN_WAIT+3 cycles.
// Backpressure: mem_ready low stalls ACCESS indefinitely; requesters hold req until ack.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int MIN_WAIT = MIN_WAIT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data,
  input  logic              mem_ready,
  output logic              busy
);

  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(MIN_WAIT);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                we_q, we_d;
  logic                last_q, last_d;   // last granted port, also the current owner
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                grant;

  rr_arbiter2 u_rr (
    .req   ({d_req, if_req}),
    .last  (last_q),
    .grant (grant)
  );

  // State register; reset abandons any in-flight access so no ack can follow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Latched command, wait counter, grant pointer and per-port read data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      last_q     <= PORT_IF;
      cnt_q      <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  // Next state: grant and latch in IDLE, count down then wait for mem_ready in ACCESS.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    case (state_q)
      IDLE: begin
        if (if_req || d_req) begin
          state_d = ACCESS;
          last_d  = grant;
          cnt_d   = WAIT_INIT;
          if (grant == PORT_D) begin
            addr_d  = d_addr;
            wdata_d = d_wdata;
            we_d    = d_we;
          end else begin
            // The fetch port is read-only.
            addr_d  = if_addr;
            wdata_d = '0;
            we_d    = 1'b0;
          end
        end
      end
      ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (mem_ready) begin
          state_d = DONE;
          // Writes leave the read-data registers untouched.
          if (!we_q) begin
            if (last_q == PORT_D) begin
              d_rdata_d = mem_read_data;
            end else begin
              if_rdata_d = mem_read_data;
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The memory command is driven only from the latched registers.
  assign mem_read       = (state_q == ACCESS) && !we_q;
  assign mem_write      = (state_q == ACCESS) && we_q;
  assign mem_address    = addr_q;
  assign mem_write_data = wdata_q;
  assign if_ack         = (state_q == DONE) && (last_q == PORT_IF);
  assign d_ack          = (state_q == DONE) && (last_q == PORT_D);
  assign if_rdata       = if_rdata_q;
  assign d_rdata        = d_rdata_q;
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (MIN_WAIT=2 main instance, MIN_WAIT=0 second instance).
// Latency: checks sampled 1 time unit after each rising clock edge.
// Backpressure: mem_ready driven per step by the bench.
module tb_mem_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;

    logic clk = 1'b0;
    logic rst;

    logic          if_req, d_req, d_we, mem_ready;
    logic [AW-1:0] if_addr, d_addr, mem_address;
    logic [DW-1:0] d_wdata, if_rdata, d_rdata, mem_write_data, mem_read_data;
    logic          if_ack, d_ack, mem_read, mem_write, busy;

    logic          b_if_req, b_d_req, b_d_we, b_mem_ready;
    logic [AW-1:0] b_if_addr, b_d_addr, b_mem_address;
    logic [DW-1:0] b_d_wdata, b_if_rdata, b_d_rdata, b_mem_write_data, b_mem_read_data;
    logic          b_if_ack, b_d_ack, b_mem_read, b_mem_write, b_busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign mem_read_data   = mem_address ^ 32'hA5A5_0000;
    assign b_mem_read_data = b_mem_address ^ 32'h5A5A_0000;

    mem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MIN_WAIT(2)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
        .mem_ready(mem_ready), .busy(busy)
    );

    mem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MIN_WAIT(0)) dut_b (
        .clk(clk), .rst(rst),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata), .if_ack(b_if_ack),
        .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
        .d_rdata(b_d_rdata), .d_ack(b_d_ack),
        .mem_read(b_mem_read), .mem_write(b_mem_write), .mem_address(b_mem_address),
        .mem_write_data(b_mem_write_data), .mem_read_data(b_mem_read_data),
        .mem_ready(b_mem_ready), .busy(b_busy)
    );

    task automatic chk(input string tag, input bit ok);
        checks++;
        if (!ok) begin
            failures++;
            $error("FAIL %s", tag);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input logic port, input int exp_n, input string tag);
        int n = 0;
        while (!(port ? d_ack : if_ack) && n < 40) begin
            tick();
            n++;
        end
        chk(tag, n === exp_n);
    endtask

    initial begin
        int acks;
        int both;
        int nack;
        int last_ack;

        rst = 1'b0;
        if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; mem_ready = 1;
        b_if_req = 0; b_if_addr = '0; b_d_req = 0; b_d_we = 0; b_d_addr = '0; b_d_wdata = '0;
        b_mem_ready = 1;

        tick();
        tick();
        chk("rst_busy", busy === 1'b0);
        chk("rst_rw", {mem_read, mem_write} === 2'b00);
        chk("rst_addr", mem_address === 32'h0);
        chk("rst_wdata", mem_write_data === 32'h0);
        chk("rst_acks", {if_ack, d_ack} === 2'b00);
        chk("rst_rdata", {if_rdata, d_rdata} === 64'h0);
        rst = 1'b1;
        tick();

        d_req = 1; d_we = 1; d_addr = 32'h408; d_wdata = 32'hDEAD_BEEF;
        for (int c = 1; c <= 3; c++) begin
            tick();
            chk($sformatf("wr_c%0d_rw", c), {mem_read, mem_write} === 2'b01);
            chk($sformatf("wr_c%0d_addr", c), mem_address === 32'h408);
            chk($sformatf("wr_c%0d_wdata", c), mem_write_data === 32'hDEAD_BEEF);
            chk($sformatf("wr_c%0d_acks", c), {if_ack, d_ack} === 2'b00);
        end
        tick();
        chk("wr_dack", d_ack === 1'b1);
        chk("wr_ifack", if_ack === 1'b0);
        chk("wr_done_rw", {mem_read, mem_write} === 2'b00);
        d_req = 0; d_we = 0;
        tick();
        chk("wr_idle_busy", busy === 1'b0);
        chk("wr_drdata_kept", d_rdata === 32'h0);

        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        if_req = 1; if_addr = 32'h100; d_req = 1; d_we = 0; d_addr = 32'h200;
        tick();
        chk("rr1_addr", mem_address === 32'h200);
        chk("rr1_read", {mem_read, mem_write} === 2'b10);
        wait_ack(1'b1, 3, "rr1_d_lat");
        chk("rr1_drdata", d_rdata === 32'hA5A5_0200);
        chk("rr1_ifack_off", if_ack === 1'b0);
        d_req = 0;
        wait_ack(1'b0, 5, "rr1_if_gap");
        chk("rr1_ifrdata", if_rdata === 32'hA5A5_0100);
        chk("rr1_dack_off", d_ack === 1'b0);
        chk("rr1_drdata_hold", d_rdata === 32'hA5A5_0200);
        if_req = 0;
        tick();

        d_req = 1; d_addr = 32'h204;
        wait_ack(1'b1, 4, "solo_d_lat");
        chk("solo_drdata", d_rdata === 32'hA5A5_0204);
        d_req = 0;
        tick();
        if_req = 1; if_addr = 32'h104; d_req = 1; d_addr = 32'h208;
        tick();
        chk("rr2_addr", mem_address === 32'h104);
        wait_ack(1'b0, 3, "rr2_if_lat");
        if_req = 0;
        wait_ack(1'b1, 5, "rr2_d_gap");
        chk("rr2_drdata", d_rdata === 32'hA5A5_0208);
        d_req = 0;
        tick();

        if_req = 1; if_addr = 32'h400; mem_ready = 0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (c == 3) if_addr = 32'h500;
            chk($sformatf("stall_c%0d_addr", c), mem_address === 32'h400);
            chk($sformatf("stall_c%0d_rd_ack", c), {mem_read, if_ack} === 2'b10);
        end
        mem_ready = 1;
        tick();
        chk("stall_ack", if_ack === 1'b1);
        chk("stall_rdata", if_rdata === 32'hA5A5_0400);
        if_req = 0;
        tick();

        d_req = 1; d_we = 1; d_addr = 32'h300; d_wdata = 32'h1234_5678;
        tick();
        tick();
        chk("rmid_write_before", mem_write === 1'b1);
        rst = 1'b0; d_req = 0; d_we = 0;
        #1;
        chk("rmid_write_drop", {mem_read, mem_write} === 2'b00);
        chk("rmid_busy", busy === 1'b0);
        chk("rmid_addr", mem_address === 32'h0);
        chk("rmid_wdata", mem_write_data === 32'h0);
        chk("rmid_rdata_clr", {if_rdata, d_rdata} === 64'h0);
        tick();
        rst = 1'b1;
        acks = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (d_ack || if_ack) acks++;
        end
        chk("rmid_no_ack", acks === 0);
        d_req = 1; d_addr = 32'h304;
        chk("rmid_idle", busy === 1'b0);
        tick();
        chk("rmid_restart_addr", mem_address === 32'h304);
        chk("rmid_restart_read", {mem_read, mem_write} === 2'b10);
        wait_ack(1'b1, 3, "rmid_lat");
        chk("rmid_drdata", d_rdata === 32'hA5A5_0304);
        d_req = 0;
        tick();

        b_d_req = 1; b_d_we = 0; b_d_addr = 32'h10;
        last_ack = -1; nack = 0; both = 0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (b_mem_read && b_mem_write) both++;
            if (b_d_ack) begin
                nack++;
                chk($sformatf("b_rdata%0d", nack), b_d_rdata === (b_d_addr ^ 32'h5A5A_0000));
                if (last_ack >= 0) begin
                    chk($sformatf("b_gap%0d", nack), (c - last_ack) === 3);
                end else begin
                    chk("b_first_lat", c === 2);
                end
                last_ack = c;
                b_d_addr = b_d_addr + 32'h4;
            end
        end
        chk("b_ack_count", nack === 4);
        chk("b_no_rw_overlap", both === 0);
        chk("b_ifack_off", b_if_ack === 1'b0);
        b_d_req = 0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
